// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scan front end for a 4x4 active-low matrix keypad.
// Drives one active-low column at a time, synchronizes the row lines, and
// latches a single pressed key as one-hot row/column indices.
//
// Parameters:
//   SCAN_DIV        - cycles each column is driven before its sample point (>= 4)
//   RELEASE_SAMPLES - consecutive absent samples before a release is declared (>= 1)
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low reset
//   rows_n      - row lines, active-low, asynchronous
//   cols_n      - column drive, active-low one-hot
//   key_pressed - high while one key is latched
//   row_idx     - one-hot latched row, 0 when idle
//   col_idx     - one-hot latched column, 0 when idle
// Build option:
//   KEYPAD_SCANNER_PRIORITY_EN - multi-row samples latch the lowest-index row
//                                instead of being rejected as ghosts.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV        = 3000,
  parameter int unsigned RELEASE_SAMPLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] rows_n,
  output logic [3:0] cols_n,
  output logic       key_pressed,
  output logic [3:0] row_idx,
  output logic [3:0] col_idx
);

  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned RW = $clog2(RELEASE_SAMPLES + 1);

  typedef enum logic [0:0] {StScan, StHold} state_e;

  state_e          state_q, state_d;
  logic [3:0]      sync1_q, sync2_q;
  logic [1:0]      col_ptr_q, col_ptr_d;
  logic [3:0]      cols_n_q, cols_n_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [RW-1:0]   rel_cnt_q, rel_cnt_d;
  logic            key_q, key_d;
  logic [3:0]      row_q, row_d;
  logic [3:0]      col_q, col_d;

  logic [3:0]      hits;
  logic            sample;
  logic            latch_ok;
  logic [3:0]      latch_row;

  assign hits   = ~sync2_q;
  assign sample = (dwell_q == DW'(SCAN_DIV - 1));

`ifdef KEYPAD_SCANNER_PRIORITY_EN
  // Isolate the lowest set bit: row 0 wins over higher rows.
  assign latch_ok  = (hits != 4'b0000);
  assign latch_row = hits & (~hits + 4'd1);
`else
  // Exactly one bit set; multi-row samples are ghosts.
  assign latch_ok  = (hits != 4'b0000) && ((hits & (hits - 4'd1)) == 4'b0000);
  assign latch_row = hits;
`endif

  always_comb begin
    state_d   = state_q;
    col_ptr_d = col_ptr_q;
    rel_cnt_d = rel_cnt_q;
    key_d     = key_q;
    row_d     = row_q;
    col_d     = col_q;
    dwell_d   = sample ? '0 : dwell_q + 1'b1;

    if (sample) begin
      unique case (state_q)
        StScan: begin
          if (latch_ok) begin
            row_d     = latch_row;
            col_d     = 4'b0001 << col_ptr_q;
            key_d     = 1'b1;
            rel_cnt_d = '0;
            state_d   = StHold;
          end else begin
            col_ptr_d = col_ptr_q + 2'd1;
          end
        end
        StHold: begin
          if ((hits & row_q) != 4'b0000) begin
            rel_cnt_d = '0;
          end else if (rel_cnt_q == RW'(RELEASE_SAMPLES - 1)) begin
            key_d     = 1'b0;
            row_d     = 4'b0000;
            col_d     = 4'b0000;
            rel_cnt_d = '0;
            col_ptr_d = col_ptr_q + 2'd1;
            state_d   = StScan;
          end else begin
            rel_cnt_d = rel_cnt_q + 1'b1;
          end
        end
        default: state_d = StScan;
      endcase
    end

    // Registered so the pins never glitch through the decode.
    cols_n_d = ~(4'b0001 << col_ptr_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StScan;
      sync1_q   <= 4'b1111;
      sync2_q   <= 4'b1111;
      col_ptr_q <= 2'd0;
      cols_n_q  <= 4'b1110;
      dwell_q   <= '0;
      rel_cnt_q <= '0;
      key_q     <= 1'b0;
      row_q     <= 4'b0000;
      col_q     <= 4'b0000;
    end else begin
      state_q   <= state_d;
      sync1_q   <= rows_n;
      sync2_q   <= sync1_q;
      col_ptr_q <= col_ptr_d;
      cols_n_q  <= cols_n_d;
      dwell_q   <= dwell_d;
      rel_cnt_q <= rel_cnt_d;
      key_q     <= key_d;
      row_q     <= row_d;
      col_q     <= col_d;
    end
  end

  assign cols_n      = cols_n_q;
  assign key_pressed = key_q;
  assign row_idx     = row_q;
  assign col_idx     = col_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed self-checking bench for keypad_scanner with
// SCAN_DIV=8, RELEASE_SAMPLES=2 and a combinational keypad matrix model.
// Build option KEYPAD_SCANNER_PRIORITY_EN selects the multi-row expectations.
module tb_keypad_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] rows_n;
  logic [3:0] cols_n;
  logic       key_pressed;
  logic [3:0] row_idx;
  logic [3:0] col_idx;

  // keys[r*4+c] set means key (row r, col c) is held.
  logic [15:0] keys;

  int n_pass;
  int n_total;

  keypad_scanner #(
    .SCAN_DIV       (8),
    .RELEASE_SAMPLES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rows_n     (rows_n),
    .cols_n     (cols_n),
    .key_pressed(key_pressed),
    .row_idx    (row_idx),
    .col_idx    (col_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    rows_n = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !cols_n[c]) rows_n[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Counts rising edges until cols_n changes (sampled 1 time unit after each edge).
  task automatic wait_cols_change(output int n);
    logic [3:0] prev;
    prev = cols_n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (cols_n === prev && n < 100);
  endtask

  task automatic wait_key(input logic lvl, input int bound);
    int n;
    n = 0;
    while (key_pressed !== lvl && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    logic stable;
    logic [3:0] exp_cols [4];
    exp_cols[0] = 4'b1101;
    exp_cols[1] = 4'b1011;
    exp_cols[2] = 4'b0111;
    exp_cols[3] = 4'b1110;
    n_pass  = 0;
    n_total = 0;
    keys    = 16'h0;
    rst_n   = 1'b0;

    // 1. Reset state and idle column scan.
    repeat (3) @(posedge clk);
    #1;
    check("rst_cols", 32'(cols_n), 32'h e);
    check("rst_key", 32'(key_pressed), 32'h0);
    check("rst_row", 32'(row_idx), 32'h0);
    check("rst_col", 32'(col_idx), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_cols_change(n);
      check("scan_period", 32'(n), 32'd8);
      check("scan_cols", 32'(cols_n), 32'(exp_cols[i]));
    end
    check("idle_key", 32'(key_pressed), 32'h0);

    // 2. Press (row1,col2).
    keys[1*4+2] = 1'b1;
    wait_key(1'b1, 34);
    check("press_key", 32'(key_pressed), 32'h1);
    check("press_row", 32'(row_idx), 32'h2);
    check("press_col", 32'(col_idx), 32'h4);
    stable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (cols_n !== 4'b1011 || key_pressed !== 1'b1 || row_idx !== 4'b0010) stable = 1'b0;
    end
    check("hold_stable", 32'(stable), 32'h1);

    // 3. Release.
    keys = 16'h0;
    wait_key(1'b0, 18);
    check("rel_key", 32'(key_pressed), 32'h0);
    check("rel_row", 32'(row_idx), 32'h0);
    check("rel_col", 32'(col_idx), 32'h0);
    check("rel_next_col", 32'(cols_n), 32'h7);

    // 4. One-window dropout and extra key during hold.
    keys[1*4+2] = 1'b1;
    wait_key(1'b1, 40);
    check("repress_key", 32'(key_pressed), 32'h1);
    keys[1*4+2] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    keys[1*4+2] = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (key_pressed !== 1'b1 || row_idx !== 4'b0010 || col_idx !== 4'b0100) stable = 1'b0;
    end
    check("dropout_hold", 32'(stable), 32'h1);
    keys[3*4+0] = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (key_pressed !== 1'b1 || row_idx !== 4'b0010 || col_idx !== 4'b0100) stable = 1'b0;
    end
    check("extra_key_ignored", 32'(stable), 32'h1);
    keys = 16'h0;
    wait_key(1'b0, 18);
    check("rel2_key", 32'(key_pressed), 32'h0);

    // 5. Two rows in one column.
    keys[0*4+1] = 1'b1;
    keys[2*4+1] = 1'b1;
`ifdef KEYPAD_SCANNER_PRIORITY_EN
    wait_key(1'b1, 40);
    check("multi_key", 32'(key_pressed), 32'h1);
    check("multi_row", 32'(row_idx), 32'h1);
    check("multi_col", 32'(col_idx), 32'h2);
    keys = 16'h0;
    wait_key(1'b0, 18);
    check("multi_rel", 32'(key_pressed), 32'h0);
`else
    stable = 1'b1;
    for (int i = 0; i < 320; i++) begin
      @(posedge clk);
      #1;
      if (key_pressed !== 1'b0 || row_idx !== 4'b0000) stable = 1'b0;
    end
    check("ghost_rejected", 32'(stable), 32'h1);
    keys = 16'h0;
`endif

    // 6. Asynchronous reset mid-hold.
    keys[1*4+2] = 1'b1;
    wait_key(1'b1, 40);
    check("pre_rst_key", 32'(key_pressed), 32'h1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_key", 32'(key_pressed), 32'h0);
    check("async_row", 32'(row_idx), 32'h0);
    check("async_col", 32'(col_idx), 32'h0);
    check("async_cols", 32'(cols_n), 32'h e);
    keys = 16'h0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_cols_change(n);
    check("restart_period", 32'(n), 32'd8);
    check("restart_cols", 32'(cols_n), 32'h d);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
